sw_alloc_rr: RTL

Round-robin switch allocator that sits directly downstream of the routing-computation stage (`router_sta_3port` / `router_sta_4port`) in each router of the 2x4 mesh. Each input port presents the output-port code computed by routing computation, and the allocator grants one input per output with packet-level locking: head flit to tail flit. It drives per-input grants and per-output crossbar selects.

---
 rtl/sw_alloc_rr.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sw_alloc_rr.sv
// Round-robin switch allocator with packet-level locking (head to tail).
// Each output independently locks to one input and releases on that input's tail transfer.
//
//   state     | meaning
//   ST_IDLE   | output free; may lock to the first candidate at or after ptr
//   ST_LOCKED | output owned by `owner` until its tail flit transfers
module sw_alloc_rr #(
  parameter int NPORT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NPORT-1:0]     req,
  input  logic [3*NPORT-1:0]   req_port,
  input  logic [NPORT-1:0]     tail,
  output logic [NPORT-1:0]     grant,
  output logic [NPORT-1:0]     out_valid,
  output logic [3*NPORT-1:0]   xbar_sel
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]       st_q    [NPORT];
  logic [0:0]       st_d    [NPORT];
  logic [2:0]       owner_q [NPORT];
  logic [2:0]       owner_d [NPORT];
  logic [2:0]       ptr_q   [NPORT];
  logic [2:0]       ptr_d   [NPORT];
  logic [NPORT-1:0] cand    [NPORT];
  logic [NPORT-1:0] rel;
  logic             found;

  logic [NPORT-1:0]   grant_d;
  logic [NPORT-1:0]   out_valid_d;
  logic [3*NPORT-1:0] xbar_d;

  // cand[o][i]: input i wants output o; codes >= NPORT never match any output
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      for (int i = 0; i < NPORT; i++) begin
        cand[o][i] = req[i] && (req_port[3*i +: 3] == 3'(o));
      end
    end
  end

  // Tail transfer of the current owner, as seen with the registered grant
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      rel[o] = 1'b0;
      for (int i = 0; i < NPORT; i++) begin
        if (owner_q[o] == 3'(i) && grant[i] && req[i] && tail[i]) begin
          rel[o] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    found = 1'b0;
    for (int o = 0; o < NPORT; o++) begin
      st_d[o]    = st_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      found      = 1'b0;
      if (st_q[o] == ST_LOCKED) begin
        // A released output is not searched on the same edge: one-cycle idle gap
        if (rel[o]) begin
          st_d[o]  = ST_IDLE;
          ptr_d[o] = (owner_q[o] == 3'(NPORT-1)) ? 3'd0 : owner_q[o] + 3'd1;
        end
      end else begin
        for (int k = 0; k < NPORT; k++) begin
          for (int i = 0; i < NPORT; i++) begin
            if (!found && cand[o][i] &&
                ((int'(ptr_q[o]) + k == i) || (int'(ptr_q[o]) + k == i + NPORT))) begin
              found      = 1'b1;
              st_d[o]    = ST_LOCKED;
              owner_d[o] = 3'(i);
            end
          end
        end
      end
    end
  end

  always_comb begin
    grant_d     = '0;
    out_valid_d = '0;
    xbar_d      = xbar_sel;
    for (int o = 0; o < NPORT; o++) begin
      if (st_d[o] == ST_LOCKED) begin
        out_valid_d[o]     = 1'b1;
        xbar_d[3*o +: 3]   = owner_d[o];
        for (int i = 0; i < NPORT; i++) begin
          if (owner_d[o] == 3'(i)) begin
            grant_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int o = 0; o < NPORT; o++) begin
        st_q[o]    <= ST_IDLE;
        owner_q[o] <= 3'd0;
        ptr_q[o]   <= 3'd0;
      end
      grant     <= '0;
      out_valid <= '0;
      xbar_sel  <= '0;
    end else if (!en) begin
      // Locks and pointers freeze; only the visible grant is withdrawn
      grant     <= '0;
      out_valid <= '0;
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        st_q[o]    <= st_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
      grant     <= grant_d;
      out_valid <= out_valid_d;
      xbar_sel  <= xbar_d;
    end
  end

endmodule
